spi_slave: RTL and testbench

SPI slave endpoint that answers the team's `spi_master` on the other end of the same four-wire link (SCLK, MOSI, MISO, SSbar). The block is oversampled: all SPI pins are synchronised into the system `clk` domain, and SCLK edges are detected there. It deserialises MOSI into `RDATA` with a one-cycle `rx_valid` strobe, and serialises a preloaded `tx_data` word onto MISO. It sits in the peripheral-side test fabric, mirroring the master's SPI mode and word-length configuration.

---
 rtl/spi_pkg.sv | 31 +++
 rtl/spi_sync_edge.sv | 24 ++
 rtl/spi_slave.sv | 163 ++++++++++++++++
 tb/tb_spi_slave.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions used by both ends of the link: modes, word length,
// status encoding and the slave state enum.
package spi_pkg;

  typedef enum logic [1:0] {
    MODE_POL_PHS_00 = 2'b00,
    MODE_POL_PHS_01 = 2'b01,
    MODE_POL_PHS_10 = 2'b10,
    MODE_POL_PHS_11 = 2'b11
  } spi_mode_t;

  localparam int unsigned DEFAULT_WORD_LENGTH = 8;

  localparam logic SPI_READY = 1'b1;
  localparam logic SPI_BUSY  = 1'b0;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StShift
  } spi_state_t;

  function automatic logic mode_cpol(spi_mode_t mode);
    return (mode == MODE_POL_PHS_10) || (mode == MODE_POL_PHS_11);
  endfunction

  function automatic logic mode_cpha(spi_mode_t mode);
    return (mode == MODE_POL_PHS_01) || (mode == MODE_POL_PHS_11);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin plus one edge register;
// rise/fall are single-cycle strobes in the clk domain.
module spi_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [2:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], din};
    end
  end

  assign rise = sync_q[1] & ~sync_q[2];
  assign fall = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/spi_slave.sv
// Oversampled SPI slave: pins are synchronised into clk, SCLK edges drive
// MSB-first RX deserialisation and TX serialisation from a holding register.
module spi_slave
  import spi_pkg::*;
#(
  parameter spi_mode_t   SPI_MODE    = MODE_POL_PHS_00,
  parameter int unsigned WORD_LENGTH = DEFAULT_WORD_LENGTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   SCLK,
  input  logic                   SSbar,
  input  logic                   MOSI,
  output logic                   MISO,
  output logic                   MISO_oe,
  input  logic [WORD_LENGTH-1:0] tx_data,
  input  logic                   tx_load,
  output logic                   tx_ready,
  output logic [WORD_LENGTH-1:0] RDATA,
  output logic                   rx_valid,
  output logic                   tx_underrun,
  output logic                   SPI_status_RDY_BSYbar
);

  localparam int unsigned CntW = $clog2(WORD_LENGTH + 1);
  localparam logic        Cpol = mode_cpol(SPI_MODE);
  localparam logic        Cpha = mode_cpha(SPI_MODE);
  localparam logic [CntW-1:0] Full = CntW'(WORD_LENGTH);

  logic sclk_rise, sclk_fall, ss_rise, ss_fall;
  logic [1:0] mosi_q;

  spi_sync_edge u_sclk_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (SCLK),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  spi_sync_edge u_ss_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (SSbar),
    .rise (ss_rise),
    .fall (ss_fall)
  );

  // MOSI shares the SCLK synchroniser depth so data and edge stay aligned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mosi_q <= '0;
    end else begin
      mosi_q <= {mosi_q[0], MOSI};
    end
  end

  spi_state_t             state_q;
  logic [WORD_LENGTH-1:0] tx_hold_q, tx_shift_q, rx_shift_q, rdata_q;
  logic [CntW-1:0]        bitcnt_q;
  logic                   tx_ready_q, miso_q, miso_oe_q, rx_valid_q, tx_underrun_q;

  logic lead_edge, trail_edge, sample_edge, shift_edge;
  logic [WORD_LENGTH-1:0] rx_next, load_word;
  logic [CntW-1:0]        bitcnt_next;
  logic                   underrun;

  assign lead_edge   = Cpol ? sclk_fall : sclk_rise;
  assign trail_edge  = Cpol ? sclk_rise : sclk_fall;
  assign sample_edge = Cpha ? trail_edge : lead_edge;
  // With CPHA=0 the MSB is already on MISO from LOAD, so a trailing edge before
  // the first sample (the previous word's last one) must not advance it.
  assign shift_edge  = Cpha ? lead_edge : (trail_edge && (bitcnt_q != '0));
  assign rx_next     = {rx_shift_q[WORD_LENGTH-2:0], mosi_q[1]};
  assign bitcnt_next = bitcnt_q + CntW'(1);

  always_comb begin
    load_word = '0;
    underrun  = 1'b0;
    if (tx_load && tx_ready_q) begin
      load_word = tx_data;
    end else if (!tx_ready_q) begin
      load_word = tx_hold_q;
    end else begin
      underrun = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      tx_hold_q     <= '0;
      tx_shift_q    <= '0;
      rx_shift_q    <= '0;
      rdata_q       <= '0;
      bitcnt_q      <= '0;
      tx_ready_q    <= 1'b1;
      miso_q        <= 1'b0;
      miso_oe_q     <= 1'b0;
      rx_valid_q    <= 1'b0;
      tx_underrun_q <= 1'b0;
    end else begin
      rx_valid_q    <= 1'b0;
      tx_underrun_q <= 1'b0;
      if (tx_load && tx_ready_q) begin
        tx_hold_q  <= tx_data;
        tx_ready_q <= 1'b0;
      end
      unique case (state_q)
        StIdle: begin
          miso_oe_q <= 1'b0;
          if (ss_fall) state_q <= StLoad;
        end
        StLoad: begin
          if (ss_rise) begin
            state_q   <= StIdle;
            miso_oe_q <= 1'b0;
            miso_q    <= 1'b0;
          end else begin
            tx_ready_q    <= 1'b1;
            tx_underrun_q <= underrun;
            tx_shift_q    <= Cpha ? load_word : (load_word << 1);
            if (!Cpha) miso_q <= load_word[WORD_LENGTH-1];
            miso_oe_q     <= 1'b1;
            bitcnt_q      <= '0;
            state_q       <= StShift;
          end
        end
        StShift: begin
          if (shift_edge) begin
            miso_q     <= tx_shift_q[WORD_LENGTH-1];
            tx_shift_q <= tx_shift_q << 1;
          end
          if (sample_edge) begin
            rx_shift_q <= rx_next;
            bitcnt_q   <= bitcnt_next;
          end
          if (sample_edge && (bitcnt_next == Full)) begin
            rdata_q    <= rx_next;
            rx_valid_q <= 1'b1;
            state_q    <= ss_rise ? StIdle : StLoad;
          end else if (ss_rise) begin
            state_q <= StIdle;
          end
          if (ss_rise) begin
            miso_oe_q <= 1'b0;
            miso_q    <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign MISO                  = miso_q;
  assign MISO_oe               = miso_oe_q;
  assign tx_ready              = tx_ready_q;
  assign RDATA                 = rdata_q;
  assign rx_valid              = rx_valid_q;
  assign tx_underrun           = tx_underrun_q;
  assign SPI_status_RDY_BSYbar = (state_q == StIdle) ? SPI_READY : SPI_BUSY;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: one instance per SPI mode on a shared bus,
// a bench-side master, and a scoreboard queue of expected RDATA words.
`timescale 1ns/1ps
module tb_spi_slave;
  import spi_pkg::*;

  localparam int W  = 8;
  localparam int HP = 5;  // SCLK half-period in clk cycles

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sclk = 1'b0;
  logic mosi = 1'b0;
  logic [W-1:0] tx_data = '0;
  logic cpol = 1'b0;
  logic cpha = 1'b0;

  logic         ssbar       [4];
  logic         tx_load     [4];
  logic         miso        [4];
  logic         miso_oe     [4];
  logic         tx_ready    [4];
  logic         rx_valid    [4];
  logic         tx_underrun [4];
  logic         status      [4];
  logic [W-1:0] rdata       [4];

  logic [W-1:0] exp_q [$];
  int nvec  = 0;
  int nfail = 0;
  int rx_cnt [4];
  int ur_cnt [4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_slave #(
      .SPI_MODE    (spi_mode_t'(g)),
      .WORD_LENGTH (W)
    ) u_dut (
      .clk                   (clk),
      .rst                   (rst),
      .SCLK                  (sclk),
      .SSbar                 (ssbar[g]),
      .MOSI                  (mosi),
      .MISO                  (miso[g]),
      .MISO_oe               (miso_oe[g]),
      .tx_data               (tx_data),
      .tx_load               (tx_load[g]),
      .tx_ready              (tx_ready[g]),
      .RDATA                 (rdata[g]),
      .rx_valid              (rx_valid[g]),
      .tx_underrun           (tx_underrun[g]),
      .SPI_status_RDY_BSYbar (status[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every rx_valid cycle pops one expected word.
  always @(negedge clk) begin
    for (int d = 0; d < 4; d++) begin
      if (rx_valid[d]) begin
        rx_cnt[d]++;
        nvec++;
        assert (exp_q.size() != 0) else begin
          nfail++;
          $error("FAIL sb_unexpected_strobe dut%0d: observed rdata %0h expected no strobe",
                 d, rdata[d]);
        end
        if (exp_q.size() != 0) check($sformatf("sb_rdata_dut%0d", d), rdata[d], exp_q.pop_front());
      end
      if (tx_underrun[d]) ur_cnt[d]++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish expected finish before time limit");
    $fatal(1);
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input int d, input logic [W-1:0] v);
    tx_data    = v;
    tx_load[d] = 1'b1;
    cycles(1);
    tx_load[d] = 1'b0;
  endtask

  task automatic select(input int d);
    cpol = (d >= 2);
    cpha = (d % 2 == 1);
    sclk = cpol;
    cycles(6);
    ssbar[d] = 1'b0;
    cycles(8);
  endtask

  task automatic deselect(input int d);
    cycles(HP);
    ssbar[d] = 1'b1;
    cycles(6);
  endtask

  task automatic xfer(input int d, input logic [W-1:0] tx, input int nbits,
                      output logic [W-1:0] rx);
    rx = '0;
    for (int i = W - 1; i >= W - nbits; i--) begin
      if (!cpha) begin
        mosi = tx[i];
        cycles(HP);
        sclk  = ~sclk;
        rx[i] = miso[d];
        cycles(HP);
        sclk = ~sclk;
      end else begin
        cycles(HP);
        sclk = ~sclk;
        mosi = tx[i];
        cycles(HP);
        sclk  = ~sclk;
        rx[i] = miso[d];
      end
    end
  endtask

  logic [W-1:0] r1, r2;
  int c0, u0;

  initial begin
    for (int d = 0; d < 4; d++) begin
      ssbar[d]   = 1'b1;
      tx_load[d] = 1'b0;
    end
    cycles(3);
    for (int d = 0; d < 4; d++) begin
      check($sformatf("rst_miso_dut%0d", d), miso[d], 1'b0);
      check($sformatf("rst_oe_dut%0d", d), miso_oe[d], 1'b0);
      check($sformatf("rst_tx_ready_dut%0d", d), tx_ready[d], 1'b1);
    end
    check("rst_rdata", rdata[0], 8'h00);
    check("rst_rx_valid", rx_valid[0], 1'b0);
    check("rst_underrun", tx_underrun[0], 1'b0);
    check("rst_status", status[0], SPI_READY);
    rst = 1'b0;
    cycles(6);

    // Mode 0 single word
    load(0, 8'hA5);
    check("m0_tx_ready_after_load", tx_ready[0], 1'b0);
    c0 = rx_cnt[0];
    exp_q.push_back(8'h3C);
    select(0);
    check("m0_oe_selected", miso_oe[0], 1'b1);
    check("m0_status_busy", status[0], SPI_BUSY);
    check("m0_tx_ready_after_start", tx_ready[0], 1'b1);
    xfer(0, 8'h3C, 8, r1);
    deselect(0);
    check("m0_miso_word", r1, 8'hA5);
    check("m0_rdata", rdata[0], 8'h3C);
    check("m0_rx_valid_count", rx_cnt[0] - c0, 1);
    check("m0_oe_idle", miso_oe[0], 1'b0);
    check("m0_status_ready", status[0], SPI_READY);

    // Modes 1..3
    for (int d = 1; d < 4; d++) begin
      load(d, 8'h7E);
      c0 = rx_cnt[d];
      exp_q.push_back(8'h81);
      select(d);
      xfer(d, 8'h81, 8, r1);
      deselect(d);
      check($sformatf("m%0d_miso_word", d), r1, 8'h7E);
      check($sformatf("m%0d_rdata", d), rdata[d], 8'h81);
      check($sformatf("m%0d_rx_valid_count", d), rx_cnt[d] - c0, 1);
    end

    // Back-to-back words under one selection
    load(0, 8'hC3);
    c0 = rx_cnt[0];
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    select(0);
    check("b2b_tx_ready_mid", tx_ready[0], 1'b1);
    load(0, 8'hF0);
    xfer(0, 8'h11, 8, r1);
    check("b2b_rdata_first", rdata[0], 8'h11);
    xfer(0, 8'h22, 8, r2);
    deselect(0);
    check("b2b_miso_first", r1, 8'hC3);
    check("b2b_miso_second", r2, 8'hF0);
    check("b2b_rdata_second", rdata[0], 8'h22);
    check("b2b_rx_valid_count", rx_cnt[0] - c0, 2);

    // Underrun; SSbar rises together with the final sample edge
    c0 = rx_cnt[1];
    u0 = ur_cnt[1];
    exp_q.push_back(8'h96);
    select(1);
    xfer(1, 8'h96, 8, r1);
    ssbar[1] = 1'b1;
    cycles(8);
    check("ur_miso_word", r1, 8'h00);
    check("ur_pulse_count", ur_cnt[1] - u0, 1);
    check("ur_rx_valid_count", rx_cnt[1] - c0, 1);
    check("ur_rdata", rdata[1], 8'h96);
    check("ur_status_ready", status[1], SPI_READY);

    // Abort after 5 bits
    load(0, 8'h33);
    c0 = rx_cnt[0];
    select(0);
    xfer(0, 8'hCD, 5, r1);
    ssbar[0] = 1'b1;
    cycles(4);
    check("abort_oe_low", miso_oe[0], 1'b0);
    cycles(4);
    check("abort_rdata_kept", rdata[0], 8'h22);
    check("abort_no_rx_valid", rx_cnt[0] - c0, 0);
    load(0, 8'h4B);
    exp_q.push_back(8'hE7);
    select(0);
    xfer(0, 8'hE7, 8, r1);
    deselect(0);
    check("abort_next_miso", r1, 8'h4B);
    check("abort_next_rdata", rdata[0], 8'hE7);

    // Reset mid-word
    load(0, 8'h99);
    select(0);
    xfer(0, 8'h00, 3, r1);
    rst = 1'b1;
    #1;
    check("midrst_miso", miso[0], 1'b0);
    check("midrst_oe", miso_oe[0], 1'b0);
    check("midrst_rdata", rdata[0], 8'h00);
    check("midrst_tx_ready", tx_ready[0], 1'b1);
    check("midrst_status", status[0], SPI_READY);
    check("midrst_rx_valid", rx_valid[0], 1'b0);
    ssbar[0] = 1'b1;
    sclk     = 1'b0;
    cycles(3);
    rst = 1'b0;
    cycles(6);
    load(0, 8'hC6);
    exp_q.push_back(8'h5A);
    select(0);
    xfer(0, 8'h5A, 8, r1);
    deselect(0);
    check("postrst_miso", r1, 8'hC6);
    check("postrst_rdata", rdata[0], 8'h5A);

    check("sb_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
